// File: rtl/pkt_sync_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_sync_framer_if
//  Description : Byte-stream handshake bundle for the packet sync framer.
//                Upstream side is di_rdy/di/di_acpt, downstream side is
//                do_rdy/do_data/do_acpt, plus lock and sync-error status.
//  Revision    : 1.0  initial release
// ============================================================================
interface pkt_sync_framer_if;
  logic       di_rdy;
  logic [7:0] di;
  logic       di_acpt;
  logic       do_rdy;
  logic [7:0] do_data;
  logic       do_acpt;
  logic       locked;
  logic       sync_err;

  // Environment side: sources input bytes and sinks output bytes.
  modport master (
    output di_rdy, di, do_acpt,
    input  di_acpt, do_rdy, do_data, locked, sync_err
  );

  // Framer side.
  modport slave (
    input  di_rdy, di, do_acpt,
    output di_acpt, do_rdy, do_data, locked, sync_err
  );
endinterface
`default_nettype wire

// File: rtl/pkt_sync_framer.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_sync_framer
//  Description : Hunts for the packet sync byte (SYNC_A or SYNC_B) at PKT_LEN
//                spacing, declares lock after LOCK_CNT good syncs and then
//                forwards whole aligned packets through a one-deep output
//                register. Bytes seen before lock are consumed and dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module pkt_sync_framer #(
  parameter int unsigned PKT_LEN    = 204,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter logic [7:0]  SYNC_A     = 8'h47,
  parameter logic [7:0]  SYNC_B     = 8'hB8
) (
  input wire               clk,
  input wire               reset_n,
  pkt_sync_framer_if.slave bus
);

  localparam logic [7:0] C_LAST_POS   = 8'(PKT_LEN - 1);
  localparam logic [7:0] C_LOCK_TGT   = 8'(LOCK_CNT);
  localparam logic [7:0] C_UNLOCK_TGT = 8'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic [7:0] good_q, good_d;
  logic [7:0] miss_q, miss_d;
  logic       do_rdy_q, do_rdy_d;
  logic [7:0] do_data_q, do_data_d;
  logic       locked_q, locked_d;
  logic       sync_err_q, sync_err_d;

  logic       w_is_sync;
  logic       w_di_acpt;
  logic       w_in_xfer;
  logic       w_out_xfer;
  logic       w_at_boundary;
  logic [7:0] w_pos_inc;
  logic       w_load;

  assign w_is_sync     = (bus.di == SYNC_A) || (bus.di == SYNC_B);
  // Outside LOCK every byte is swallowed; in LOCK we accept only when the
  // output register is empty or being drained this cycle.
  assign w_di_acpt     = (state_q == ST_LOCK) ? (!do_rdy_q || bus.do_acpt) : 1'b1;
  assign w_in_xfer     = bus.di_rdy && w_di_acpt;
  assign w_out_xfer    = do_rdy_q && bus.do_acpt;
  assign w_at_boundary = (pos_q == 8'd0);
  assign w_pos_inc     = (pos_q == C_LAST_POS) ? 8'd0 : pos_q + 8'd1;

  // Sync hunt / verify / lock sequencing, evaluated once per accepted byte.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    good_d     = good_q;
    miss_d     = miss_q;
    sync_err_d = 1'b0;
    w_load     = 1'b0;

    if (w_in_xfer) begin
      case (state_q)
        ST_HUNT: begin
          if (w_is_sync) begin
            pos_d  = 8'd1;
            good_d = 8'd1;
            if (C_LOCK_TGT <= 8'd1) begin
              state_d = ST_LOCK;
              miss_d  = 8'd0;
              w_load  = 1'b1;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end

        ST_VERIFY: begin
          pos_d = w_pos_inc;
          if (w_at_boundary) begin
            if (w_is_sync) begin
              good_d = good_q + 8'd1;
              if (good_q + 8'd1 >= C_LOCK_TGT) begin
                state_d = ST_LOCK;
                miss_d  = 8'd0;
                w_load  = 1'b1;
              end
            end else begin
              // The failing byte is not reconsidered as a fresh sync candidate.
              state_d = ST_HUNT;
              pos_d   = 8'd0;
              good_d  = 8'd0;
            end
          end
        end

        ST_LOCK: begin
          pos_d  = w_pos_inc;
          w_load = 1'b1;
          if (w_at_boundary) begin
            if (w_is_sync) begin
              miss_d = 8'd0;
            end else begin
              sync_err_d = 1'b1;
              if (miss_q + 8'd1 >= C_UNLOCK_TGT) begin
                // Drop the bad boundary byte so output ends on a whole packet.
                state_d = ST_HUNT;
                pos_d   = 8'd0;
                good_d  = 8'd0;
                miss_d  = 8'd0;
                w_load  = 1'b0;
              end else begin
                // Tolerated miss: keep alignment and forward the byte.
                miss_d = miss_q + 8'd1;
              end
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
          pos_d   = 8'd0;
          good_d  = 8'd0;
          miss_d  = 8'd0;
        end
      endcase
    end
  end

  // One-deep output register: drain on downstream accept, refill on load.
  always_comb begin
    do_rdy_d  = do_rdy_q;
    do_data_d = do_data_q;
    locked_d  = (state_d == ST_LOCK);
    if (w_out_xfer) begin
      do_rdy_d = 1'b0;
    end
    if (w_load) begin
      do_rdy_d  = 1'b1;
      do_data_d = bus.di;
    end
  end

  // State and output registers; reset clears everything including a held byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HUNT;
      pos_q      <= 8'd0;
      good_q     <= 8'd0;
      miss_q     <= 8'd0;
      do_rdy_q   <= 1'b0;
      do_data_q  <= 8'd0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      do_rdy_q   <= do_rdy_d;
      do_data_q  <= do_data_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.di_acpt  = w_di_acpt;
  assign bus.do_rdy   = do_rdy_q;
  assign bus.do_data  = do_data_q;
  assign bus.locked   = locked_q;
  assign bus.sync_err = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_sync_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_sync_framer
//  Description : Directed self-checking bench for pkt_sync_framer with a
//                byte-level reference model and a per-cycle compare process.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pkt_sync_framer;
  localparam int PKT_LEN    = 204;
  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pkt_sync_framer_if bus ();

  pkt_sync_framer #(
    .PKT_LEN   (PKT_LEN),
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT),
    .SYNC_A    (8'h47),
    .SYNC_B    (8'hB8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase < 0 means hunting, else offset of next byte in packet.
  int         m_phase = -1;
  int         m_run   = 0;
  int         m_miss  = 0;
  bit         m_lk    = 1'b0;
  bit         m_err   = 1'b0;
  logic [7:0] m_q[$];

  int         n_out    = 0;
  logic [7:0] last_out = 8'h00;
  bit         busy_acpt_mode = 1'b0;
  bit         gap_mode       = 1'b0;

  task automatic fail_line(input string name, input int act, input int exp);
    n_err++;
    $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) fail_line(name, int'(act), int'(exp));
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) fail_line(name, int'(act), int'(exp));
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) fail_line(name, act, exp);
  endtask

  function automatic logic [7:0] pay(input int p, input int i);
    logic [7:0] v;
    v = 8'((p * 31 + i * 7 + 5) % 256);
    if (v == 8'h47 || v == 8'hB8) v = v ^ 8'h01;
    return v;
  endfunction

  // Feed one accepted input byte through the framing rules.
  function automatic void model_byte(input logic [7:0] b);
    bit sy;
    bit boundary;
    sy = (b == 8'h47) || (b == 8'hB8);
    if (m_phase < 0) begin
      if (sy) begin
        m_run   = 1;
        m_phase = 1;
        if (m_run >= LOCK_CNT) begin
          m_lk = 1'b1; m_miss = 0; m_q.push_back(b);
        end
      end
      return;
    end
    boundary = (m_phase == 0);
    m_phase  = (m_phase + 1) % PKT_LEN;
    if (!m_lk) begin
      if (boundary && sy) begin
        m_run++;
        if (m_run >= LOCK_CNT) begin
          m_lk = 1'b1; m_miss = 0; m_q.push_back(b);
        end
      end else if (boundary) begin
        m_phase = -1; m_run = 0;
      end
    end else if (boundary && !sy) begin
      m_err = 1'b1;
      m_miss++;
      if (m_miss >= UNLOCK_CNT) begin
        m_lk = 1'b0; m_phase = -1; m_run = 0;
      end else begin
        m_q.push_back(b);
      end
    end else begin
      if (boundary) m_miss = 0;
      m_q.push_back(b);
    end
  endfunction

  // Compare process: outputs are registered, so mid-cycle values are stable.
  always @(negedge clk) begin : p_cmp
    if (!reset_n) begin
      check1("rst_do_rdy", bus.do_rdy, 1'b0);
      check1("rst_locked", bus.locked, 1'b0);
      check1("rst_sync_err", bus.sync_err, 1'b0);
      check8("rst_do_data", bus.do_data, 8'h00);
      m_phase = -1; m_run = 0; m_miss = 0; m_lk = 1'b0; m_err = 1'b0;
      m_q.delete();
    end else begin
      check1("locked", bus.locked, m_lk);
      check1("sync_err", bus.sync_err, m_err);
      check1("do_rdy", bus.do_rdy, m_q.size() != 0);
      if (bus.do_rdy && m_q.size() != 0) check8("do_data", bus.do_data, m_q[0]);
      check1("di_acpt", bus.di_acpt, !m_lk || m_q.size() == 0 || bus.do_acpt);
      if (bus.do_rdy && bus.do_acpt) begin
        last_out = bus.do_data;
        n_out++;
        if (m_q.size() != 0) void'(m_q.pop_front());
      end
      m_err = 1'b0;
      if (bus.di_rdy && bus.di_acpt) model_byte(bus.di);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit done;
    done = 1'b0;
    if (gap_mode && $urandom_range(0, 5) == 0) begin
      bus.di_rdy  = 1'b0;
      bus.do_acpt = 1'b1;
      tick();
    end
    bus.di_rdy = 1'b1;
    bus.di     = b;
    for (int k = 0; k < 64 && !done; k++) begin
      bus.do_acpt = busy_acpt_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      done = bus.di_acpt;
      tick();
    end
    bus.di_rdy = 1'b0;
    if (!done) begin
      n_vec++;
      fail_line("send_timeout", 0, 1);
    end
  endtask

  task automatic send_pkt(input int p, input logic [7:0] s, input int nbytes = PKT_LEN);
    send(s);
    for (int i = 1; i < nbytes; i++) send(pay(p, i));
  endtask

  task automatic drain();
    bus.di_rdy  = 1'b0;
    bus.do_acpt = 1'b1;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    bus.di_rdy  = 1'b0;
    bus.do_acpt = 1'b1;
    reset_n     = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    n_out = 0;
  endtask

  task automatic t1_clean();
    do_reset();
    send_pkt(0, 8'h47);
    send_pkt(1, 8'h47);
    checki("t1_no_out_prelock", n_out, 0);
    check1("t1_prelock", bus.locked, 1'b0);
    send(8'h47);
    check1("t1_locked", bus.locked, 1'b1);
    check1("t1_first_rdy", bus.do_rdy, 1'b1);
    check8("t1_first_byte", bus.do_data, 8'h47);
    for (int i = 1; i < PKT_LEN; i++) send(pay(2, i));
    send_pkt(3, 8'h47);
    send_pkt(4, 8'h47);
    drain();
    checki("t1_out_count", n_out, 612);
  endtask

  task automatic t2_false_sync();
    logic [7:0] g;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      g = pay(100, i);
      if (i == 10)  g = 8'h47;
      if (i == 214) g = 8'h00;
      send(g);
      if (i == 214) begin
        check1("t2_unlocked", bus.locked, 1'b0);
        check1("t2_no_rdy", bus.do_rdy, 1'b0);
      end
    end
    send_pkt(10, 8'h47);
    send_pkt(11, 8'h47);
    checki("t2_no_out_prelock", n_out, 0);
    send(8'h47);
    check1("t2_locked", bus.locked, 1'b1);
    for (int i = 1; i < PKT_LEN; i++) send(pay(12, i));
    drain();
    checki("t2_out_count", n_out, 204);
  endtask

  task automatic t3_stall();
    do_reset();
    send_pkt(20, 8'h47);
    send_pkt(21, 8'h47);
    send_pkt(22, 8'h47);
    send_pkt(23, 8'h47, 50);
    bus.do_acpt = 1'b0;
    bus.di_rdy  = 1'b1;
    bus.di      = pay(23, 50);
    repeat (5) begin
      @(negedge clk);
      check1("t3_stall_acpt", bus.di_acpt, 1'b0);
      check1("t3_stall_rdy", bus.do_rdy, 1'b1);
      check8("t3_stall_data", bus.do_data, pay(23, 49));
      tick();
    end
    bus.do_acpt = 1'b1;
    for (int i = 50; i < PKT_LEN; i++) send(pay(23, i));
    send_pkt(24, 8'h47);
    drain();
    checki("t3_out_count", n_out, 612);
  endtask

  task automatic t4_sync_errors();
    do_reset();
    send_pkt(30, 8'h47);
    send_pkt(31, 8'h47);
    send_pkt(32, 8'h47);
    send(8'h12);
    check1("t4_err_pulse", bus.sync_err, 1'b1);
    check1("t4_still_locked", bus.locked, 1'b1);
    check8("t4_bad_fwd", bus.do_data, 8'h12);
    send(pay(33, 1));
    check1("t4_err_cleared", bus.sync_err, 1'b0);
    for (int i = 2; i < PKT_LEN; i++) send(pay(33, i));
    send_pkt(34, 8'h47);
    send_pkt(35, 8'h12);
    send_pkt(36, 8'h34);
    check1("t4_locked_2miss", bus.locked, 1'b1);
    send(8'h56);
    check1("t4_unlocked", bus.locked, 1'b0);
    check1("t4_err_3rd", bus.sync_err, 1'b1);
    check1("t4_dropped", bus.do_rdy, 1'b0);
    for (int i = 1; i < 20; i++) send(pay(37, i));
    drain();
    check8("t4_last_out", last_out, pay(36, 203));
    checki("t4_out_count", n_out, 1020);
  endtask

  task automatic t5_alternate();
    do_reset();
    busy_acpt_mode = 1'b1;
    gap_mode       = 1'b1;
    send_pkt(40, 8'h47);
    send_pkt(41, 8'hB8);
    send(8'h47);
    check1("t5_locked", bus.locked, 1'b1);
    check8("t5_sync_a", bus.do_data, 8'h47);
    for (int i = 1; i < PKT_LEN; i++) send(pay(42, i));
    send(8'hB8);
    check8("t5_sync_b", bus.do_data, 8'hB8);
    for (int i = 1; i < PKT_LEN; i++) send(pay(43, i));
    busy_acpt_mode = 1'b0;
    gap_mode       = 1'b0;
    drain();
    checki("t5_out_count", n_out, 408);
  endtask

  task automatic t6_reset_in_lock();
    do_reset();
    send_pkt(50, 8'h47);
    send_pkt(51, 8'h47);
    send_pkt(52, 8'h47);
    send_pkt(53, 8'h47, 60);
    check1("t6_rdy_before", bus.do_rdy, 1'b1);
    reset_n = 1'b0;
    #1;
    check1("t6_rdy_async", bus.do_rdy, 1'b0);
    check1("t6_locked_async", bus.locked, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_out = 0;
    send_pkt(54, 8'h47);
    send_pkt(55, 8'h47);
    check1("t6_prelock", bus.locked, 1'b0);
    send(8'h47);
    check1("t6_relocked", bus.locked, 1'b1);
    for (int i = 1; i < PKT_LEN; i++) send(pay(56, i));
    drain();
    checki("t6_out_count", n_out, 204);
  endtask

  initial begin
    bus.di_rdy  = 1'b0;
    bus.di      = 8'h00;
    bus.do_acpt = 1'b1;
    tick();
    tick();
    check1("reset_di_acpt", bus.di_acpt, 1'b1);
    check1("reset_do_rdy", bus.do_rdy, 1'b0);
    check8("reset_do_data", bus.do_data, 8'h00);
    check1("reset_locked", bus.locked, 1'b0);
    check1("reset_sync_err", bus.sync_err, 1'b0);

    t1_clean();
    t2_false_sync();
    t3_stall();
    t4_sync_errors();
    t5_alternate();
    t6_reset_in_lock();

    drain();
    checki("final_queue_empty", m_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
